// File: rtl/pattern_sequencer_if.sv
// Bundle of raster position, control inputs, generator colours and selector
// outputs shared between the pattern sequencer and its driver.
interface pattern_sequencer_if #(
  parameter int NUM_PATTERNS = 2
);
  localparam int SEL_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;

  logic [9:0]                x;
  logic [9:0]                y;
  logic                      active;
  logic                      vsync;
  logic                      paused;
  logic                      auto_mode;
  logic                      next_req;
  logic                      prev_req;
  logic [NUM_PATTERNS*6-1:0] rgb_in;
  logic [5:0]                rgb;
  logic [SEL_W-1:0]          pattern_sel;
  logic [NUM_PATTERNS-1:0]   pattern_en;
  logic [NUM_PATTERNS-1:0]   gen_active;
  logic [NUM_PATTERNS-1:0]   gen_next_frame;
  logic                      switch_pulse;

  modport master (
    output x, y, active, vsync, paused, auto_mode, next_req, prev_req, rgb_in,
    input  rgb, pattern_sel, pattern_en, gen_active, gen_next_frame, switch_pulse
  );

  modport slave (
    input  x, y, active, vsync, paused, auto_mode, next_req, prev_req, rgb_in,
    output rgb, pattern_sel, pattern_en, gen_active, gen_next_frame, switch_pulse
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Selects one of NUM_PATTERNS generators, rotating on a per-pattern frame dwell
// or on manual next/prev edges; switches only at the frame origin (x=0, y=0).
module pattern_sequencer #(
  parameter int                               NUM_PATTERNS = 2,
  parameter int                               FRAME_W      = 10,
  parameter logic [NUM_PATTERNS*FRAME_W-1:0]  DURATIONS    = {10'd480, 10'd240}
) (
  input  logic               clk,
  input  logic               rst,
  pattern_sequencer_if.slave bus
);
  localparam int SEL_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam int TAB_N = 1 << SEL_W;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_dir_prev;
  logic               w_dir_prev_next;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_next;
  logic [FRAME_W-1:0] r_cnt;
  logic [FRAME_W-1:0] w_cnt_next;
  logic               r_vsync_q;
  logic               r_next_q;
  logic               r_prev_q;
  logic               r_switch;

  logic [FRAME_W-1:0] w_dur_tab [TAB_N];
  logic [5:0]         w_rgb_tab [TAB_N];
  logic [FRAME_W-1:0] w_cur_dur;
  logic               w_trigger;
  logic               w_cnt_inc;
  logic               w_auto_req;
  logic               w_next_edge;
  logic               w_prev_edge;
  logic               w_man_next;
  logic               w_man_prev;
  logic               w_req;
  logic               w_origin;
  logic               w_commit;
  logic [SEL_W-1:0]   w_sel_inc;
  logic [SEL_W-1:0]   w_sel_dec;

  // Tables padded to a power of two so r_sel can never index out of range.
  genvar gi;
  generate
    for (gi = 0; gi < TAB_N; gi++) begin : g_tab
      if (gi < NUM_PATTERNS) begin : g_used
        assign w_dur_tab[gi] = DURATIONS[gi*FRAME_W +: FRAME_W];
        assign w_rgb_tab[gi] = bus.rgb_in[gi*6 +: 6];
      end else begin : g_unused
        assign w_dur_tab[gi] = '0;
        assign w_rgb_tab[gi] = '0;
      end
    end

    for (gi = 0; gi < NUM_PATTERNS; gi++) begin : g_en
      assign bus.pattern_en[gi]     = (r_sel == SEL_W'(gi));
      assign bus.gen_active[gi]     = bus.pattern_en[gi] & bus.active;
      assign bus.gen_next_frame[gi] = bus.pattern_en[gi] & w_trigger;
    end
  endgenerate

  assign w_cur_dur   = w_dur_tab[r_sel];
  assign w_trigger   = bus.vsync & ~r_vsync_q & ~bus.paused;
  assign w_cnt_inc   = w_trigger & bus.auto_mode & (w_cur_dur != '0);
  assign w_auto_req  = w_cnt_inc & (r_cnt == (w_cur_dur - FRAME_W'(1)));

  assign w_next_edge = bus.next_req & ~r_next_q;
  assign w_prev_edge = bus.prev_req & ~r_prev_q;
  assign w_man_next  = w_next_edge & ~w_prev_edge;
  assign w_man_prev  = w_prev_edge & ~w_next_edge;
  assign w_req       = w_auto_req | w_man_next | w_man_prev;

  assign w_origin    = (bus.x == 10'd0) && (bus.y == 10'd0);
  assign w_commit    = (r_state == ST_PENDING) && w_origin;

  assign w_sel_inc   = (r_sel == SEL_W'(NUM_PATTERNS - 1)) ? '0 : r_sel + SEL_W'(1);
  assign w_sel_dec   = (r_sel == '0) ? SEL_W'(NUM_PATTERNS - 1) : r_sel - SEL_W'(1);

  // A request landing on the commit edge survives the commit as a new pending step.
  always_comb begin
    w_state_next    = r_state;
    w_dir_prev_next = r_dir_prev;
    w_sel_next      = r_sel;
    w_cnt_next      = r_cnt;

    if (w_cnt_inc) begin
      w_cnt_next = w_auto_req ? '0 : r_cnt + FRAME_W'(1);
    end

    if (w_commit) begin
      w_sel_next   = r_dir_prev ? w_sel_dec : w_sel_inc;
      w_cnt_next   = '0;
      w_state_next = ST_IDLE;
    end

    if (w_req) begin
      w_state_next    = ST_PENDING;
      w_dir_prev_next = w_man_prev;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dir_prev <= 1'b0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_vsync_q  <= 1'b1;
      r_next_q   <= 1'b1;
      r_prev_q   <= 1'b1;
      r_switch   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_dir_prev <= w_dir_prev_next;
      r_sel      <= w_sel_next;
      r_cnt      <= w_cnt_next;
      r_vsync_q  <= bus.vsync;
      r_next_q   <= bus.next_req;
      r_prev_q   <= bus.prev_req;
      r_switch   <= w_commit;
    end
  end

  assign bus.pattern_sel  = r_sel;
  assign bus.switch_pulse = r_switch;
  assign bus.rgb          = bus.active ? w_rgb_tab[r_sel] : 6'd0;
endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench: a 2-pattern default instance and a 5-pattern instance with a
// zero-dwell entry share one compact 4-cycle frame stimulus.
module tb_pattern_sequencer;
  localparam logic [19:0] DUR2 = {10'd480, 10'd240};
  localparam logic [49:0] DUR5 = {10'd2, 10'd2, 10'd0, 10'd2, 10'd2};

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y;
  logic       active, vsync, paused, auto_mode, next_req, prev_req;

  int n_checks = 0;
  int n_pass   = 0;
  int sw2_cnt  = 0;

  logic [1:0] last_gnf2;
  logic [4:0] last_gnf5;
  logic       last_sw_a, last_sw_b;

  always #5 clk = ~clk;

  pattern_sequencer_if #(.NUM_PATTERNS(2)) bus2 ();
  pattern_sequencer_if #(.NUM_PATTERNS(5)) bus5 ();

  assign bus2.x = x;          assign bus5.x = x;
  assign bus2.y = y;          assign bus5.y = y;
  assign bus2.active = active;       assign bus5.active = active;
  assign bus2.vsync = vsync;         assign bus5.vsync = vsync;
  assign bus2.paused = paused;       assign bus5.paused = paused;
  assign bus2.auto_mode = auto_mode; assign bus5.auto_mode = auto_mode;
  assign bus2.next_req = next_req;   assign bus5.next_req = next_req;
  assign bus2.prev_req = prev_req;   assign bus5.prev_req = prev_req;
  assign bus2.rgb_in = {6'h2A, 6'h15};
  assign bus5.rgb_in = {6'd39, 6'd30, 6'd21, 6'd12, 6'd3};

  pattern_sequencer #(.NUM_PATTERNS(2), .FRAME_W(10), .DURATIONS(DUR2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  pattern_sequencer #(.NUM_PATTERNS(5), .FRAME_W(10), .DURATIONS(DUR5)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  always @(negedge clk) begin
    if (bus2.switch_pulse) sw2_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s = %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vsync low, vsync rise, frame origin, back to mid-frame.
  task automatic frame();
    x = 10'd5; y = 10'd5; vsync = 1'b0;
    tick();
    vsync = 1'b1;
    #1;
    last_gnf2 = bus2.gen_next_frame;
    last_gnf5 = bus5.gen_next_frame;
    tick();
    x = 10'd0; y = 10'd0;
    tick();
    last_sw_a = bus2.switch_pulse;
    x = 10'd5; y = 10'd5;
    tick();
    last_sw_b = bus2.switch_pulse;
  endtask

  task automatic pulse_next();
    next_req = 1'b1; tick();
    next_req = 1'b0; tick();
  endtask

  task automatic pulse_prev();
    prev_req = 1'b1; tick();
    prev_req = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; x = 10'd5; y = 10'd5; active = 1'b1; vsync = 1'b1;
    paused = 1'b0; auto_mode = 1'b0; next_req = 1'b0; prev_req = 1'b0;
    tick(); tick();
    check_eq("rst_sel", 32'(bus2.pattern_sel), 32'd0);
    check_eq("rst_en", 32'(bus2.pattern_en), 32'h1);
    check_eq("rst_switch", 32'(bus2.switch_pulse), 32'd0);
    check_eq("rst_gen_active", 32'(bus2.gen_active), 32'h1);
    check_eq("rst_rgb", 32'(bus2.rgb), 32'h15);
    rst = 1'b0;

    // Timed rotation: 240-frame dwell on pattern 0
    auto_mode = 1'b1;
    repeat (239) frame();
    check_eq("dwell239_sel", 32'(bus2.pattern_sel), 32'd0);
    check_eq("dwell239_sw", 32'(sw2_cnt), 32'd0);
    check_eq("gnf_p0", 32'(last_gnf2), 32'h1);
    frame();
    check_eq("dwell240_sel", 32'(bus2.pattern_sel), 32'd1);
    check_eq("sw_pulse_on", 32'(last_sw_a), 32'd1);
    check_eq("sw_pulse_off", 32'(last_sw_b), 32'd0);

    active = 1'b0; #1;
    check_eq("rgb_blank", 32'(bus2.rgb), 32'd0);
    check_eq("gen_active_blank", 32'(bus2.gen_active), 32'd0);
    active = 1'b1; #1;
    check_eq("rgb_p1", 32'(bus2.rgb), 32'h2A);
    check_eq("gen_active_p1", 32'(bus2.gen_active), 32'h2);

    // 480-frame dwell with 100 paused frames inserted
    repeat (200) frame();
    paused = 1'b1;
    repeat (100) frame();
    check_eq("gnf_paused", 32'(last_gnf2), 32'd0);
    paused = 1'b0;
    repeat (279) frame();
    check_eq("dwell479_sel", 32'(bus2.pattern_sel), 32'd1);
    frame();
    check_eq("dwell480_sel", 32'(bus2.pattern_sel), 32'd0);
    check_eq("sw_count_auto", 32'(sw2_cnt), 32'd2);

    // Manual prev with wrap, then no auto rotation
    auto_mode = 1'b0;
    pulse_prev();
    check_eq("prev_wait_origin", 32'(bus2.pattern_sel), 32'd0);
    frame();
    check_eq("prev_wrap", 32'(bus2.pattern_sel), 32'd1);
    repeat (1000) frame();
    check_eq("manual_hold", 32'(bus2.pattern_sel), 32'd1);

    // Coincident edges ignored; held next gives one step
    next_req = 1'b1; prev_req = 1'b1; tick();
    frame();
    check_eq("coincident", 32'(bus2.pattern_sel), 32'd1);
    next_req = 1'b0; prev_req = 1'b0; tick();
    next_req = 1'b1;
    repeat (3) frame();
    check_eq("next_held", 32'(bus2.pattern_sel), 32'd0);
    next_req = 1'b0; tick();
    check_eq("sw_count_manual", 32'(sw2_cnt), 32'd4);

    // Reset discards a pending request
    pulse_next();
    frame();
    check_eq("next_step", 32'(bus2.pattern_sel), 32'd1);
    pulse_next();
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("rst_pending_sel", 32'(bus2.pattern_sel), 32'd0);
    frame();
    check_eq("rst_discard_sel", 32'(bus2.pattern_sel), 32'd0);
    check_eq("rst_discard_sw", 32'(last_sw_a), 32'd0);

    // Five patterns, pattern 2 holds indefinitely
    rst = 1'b1; tick(); rst = 1'b0;
    auto_mode = 1'b1;
    frame(); frame();
    check_eq("n5_step1", 32'(bus5.pattern_sel), 32'd1);
    frame(); frame();
    check_eq("n5_step2", 32'(bus5.pattern_sel), 32'd2);
    repeat (10) frame();
    check_eq("n5_halt", 32'(bus5.pattern_sel), 32'd2);
    check_eq("n5_gnf", 32'(last_gnf5), 32'h04);
    auto_mode = 1'b0;
    pulse_next(); frame();
    check_eq("n5_next3", 32'(bus5.pattern_sel), 32'd3);
    check_eq("n5_rgb3", 32'(bus5.rgb), 32'd30);
    pulse_next(); frame();
    check_eq("n5_next4", 32'(bus5.pattern_sel), 32'd4);
    pulse_next(); frame();
    check_eq("n5_wrap0", 32'(bus5.pattern_sel), 32'd0);
    pulse_next(); pulse_prev(); frame();
    check_eq("n5_overwrite", 32'(bus5.pattern_sel), 32'd4);
    pulse_next(); frame();
    check_eq("n5_back0", 32'(bus5.pattern_sel), 32'd0);

    // Manual prev on the same edge as an auto request wins
    auto_mode = 1'b1;
    frame();
    x = 10'd5; y = 10'd5; vsync = 1'b0; tick();
    vsync = 1'b1; prev_req = 1'b1; tick();
    x = 10'd0; y = 10'd0; tick();
    x = 10'd5; y = 10'd5; prev_req = 1'b0; tick();
    check_eq("n5_manual_wins", 32'(bus5.pattern_sel), 32'd4);
    auto_mode = 1'b0;

    // Request on the commit edge stays pending
    pulse_prev();
    x = 10'd0; y = 10'd0; next_req = 1'b1; tick();
    check_eq("n5_commit_req", 32'(bus5.pattern_sel), 32'd3);
    x = 10'd5; y = 10'd5; next_req = 1'b0; tick();
    frame();
    check_eq("n5_req_kept", 32'(bus5.pattern_sel), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter NUM_PATTERNS, 2, number of pattern generators (legal range 2..8).
REQ-002 Parameter FRAME_W, 10, width of the frame counter and of each duration field.
REQ-003 Parameter DURATIONS, {10'd480,10'd240}, packed NUM_PATTERNS*FRAME_W; pattern i dwell in frames at [i*FRAME_W +: FRAME_W]; value 0 = hold indefinitely.
REQ-004 Local SEL_W = clog2(NUM_PATTERNS), minimum 1.
REQ-005 clk  input  1  pixel clock; single clock domain.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 x  input  10  current pixel column.
REQ-008 y  input  10  current pixel row.
REQ-009 active  input  1  visible-area flag.
REQ-010 vsync  input  1  active-low vertical sync.
REQ-011 paused  input  1  freezes animation and auto-advance.
REQ-012 auto_mode  input  1  1 = timed rotation; 0 = manual only.
REQ-013 next_req  input  1  level input; rising edge requests the next pattern.
REQ-014 prev_req  input  1  level input; rising edge requests the previous pattern.
REQ-015 rgb_in  input  NUM_PATTERNS*6  packed generator outputs; pattern i at [i*6 +: 6].
REQ-016 rgb  output  6  selected pixel colour.
REQ-017 pattern_sel  output  SEL_W  current pattern index (registered).
REQ-018 pattern_en  output  NUM_PATTERNS  one-hot of pattern_sel.
REQ-019 gen_active  output  NUM_PATTERNS  pattern_en gated by active.
REQ-020 gen_next_frame  output  NUM_PATTERNS  pattern_en gated by animation trigger.
REQ-021 switch_pulse  output  1  one-cycle pulse on the cycle pattern_sel changes.

Function
REQ-022 vsync_rise SHALL be vsync & ~vsync_q, with vsync_q a one-cycle delayed copy of vsync.
REQ-023 Animation trigger SHALL be vsync_rise & ~paused; gen_next_frame[i] = trigger & pattern_en[i], combinational.
REQ-024 Frame counter (FRAME_W bits) SHALL increment on trigger only when auto_mode=1 and the current duration is nonzero.
REQ-025 When the counter equals duration-1 on an increment event, it SHALL clear to 0 and set pending with direction +1.
REQ-026 Duration 1 SHALL produce a pending request on every trigger; duration 0 SHALL never auto-advance, and the counter SHALL hold at 0.
REQ-027 Rising edges of next_req/prev_req (edge registers reset to 1) SHALL set pending with direction +1/-1 respectively, regardless of auto_mode or paused.
REQ-028 Coincident next and prev edges SHALL be ignored; a manual edge coinciding with an auto request SHALL take precedence and set its own direction.
REQ-029 Additional requests while pending is already set SHALL overwrite the direction only; at most one step occurs per commit.
REQ-030 Commit SHALL occur on a clock edge where pending=1 and x==0 and y==0: pattern_sel steps by the pending direction, pending clears, the frame counter clears, and switch_pulse is asserted during the following cycle.
REQ-031 Step wrap: +1 from NUM_PATTERNS-1 SHALL give 0; -1 from 0 SHALL give NUM_PATTERNS-1.
REQ-032 A request event and a commit on the same edge: the commit SHALL proceed and the new request SHALL remain pending.
REQ-033 rgb SHALL be rgb_in[pattern_sel*6 +: 6], combinational, and 0 whenever active=0.
REQ-034 auto_mode falling SHALL not cancel an already-pending request; the counter SHALL hold its value while auto_mode=0.

Reset
REQ-035 On rst=1 at a clock edge: pattern_sel=0, counter=0, pending=0, switch_pulse=0, vsync_q=1, and both request edge registers=1.
REQ-036 Following reset, pattern_en=1, with gen_active and gen_next_frame following REQ-019/REQ-023 from the first cycle.
REQ-037 Reset asserted mid-pending SHALL discard the request; reset SHALL have priority over every event.

Verification
REQ-038 Defaults, auto_mode=1, 240 vsync pulses -> pending after 240th rise; pattern_sel=1 at the next x=0,y=0; switch_pulse high exactly 1 cycle.
REQ-039 pattern_sel=1, 480 further frames -> pattern_sel wraps to 0; paused=1 for 100 frames inserted -> switch delayed by exactly 100 frames.
REQ-040 auto_mode=0, prev_req pulse at pattern 0 -> pattern_sel=1 (wrap to NUM_PATTERNS-1) at next frame origin; no auto switch after 1000 frames.
REQ-041 next_req and prev_req rising together -> no pending, pattern_sel unchanged; next_req held high for 3 frames -> single step.
REQ-042 NUM_PATTERNS=5, DURATIONS with entry 2 = 0 -> rotation 0->1->2 halts at 2; next_req -> 3.
REQ-043 rst pulse while pending set -> pattern_sel=0, no switch_pulse at the next frame origin; rgb=0 whenever active=0.
